// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main decoder. Steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives per-cycle datapath enables,
// stalls on mem_ready with a bounded watchdog, traps illegal opcodes and
// counts retired instructions.
//   clk, rst_n          clock, asynchronous active-low reset
//   op, mem_ready, zero opcode (valid from DECODE), memory handshake, ALU zero
//   pcwrite..jalsrc     datapath enables and mux selects
//   aluop, funct        ALU class/function to the ALU decoder
//   illegal, mem_err    one-cycle trap pulses
//   retired             retired-instruction count
module mc_maindec #(
  parameter int OPW  = 6,
  parameter int CNTW = 32,
  parameter int TMO  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  op,
  input  logic            mem_ready,
  input  logic            zero,
  output logic            pcwrite,
  output logic            pcwrite_br,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic            jalsrc,
  output logic [1:0]      aluop,
  output logic [3:0]      funct,
  output logic            illegal,
  output logic            mem_err,
  output logic [CNTW-1:0] retired
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;
  localparam int WW = $clog2(TMO + 1);
  localparam logic [OPW-1:0] OP_LW  = OPW'(6'h20);
  localparam logic [OPW-1:0] OP_SW  = OPW'(6'h21);
  localparam logic [OPW-1:0] OP_AI0 = OPW'(6'h22);
  localparam logic [OPW-1:0] OP_AI1 = OPW'(6'h2B);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(6'h10);
  localparam logic [OPW-1:0] OP_J   = OPW'(6'h30);
  localparam logic [OPW-1:0] OP_JAL = OPW'(6'h31);
  localparam logic [OPW-1:0] OP_JR  = OPW'(6'h33);
  state_t          state_q, state_d, dec_ns;
  logic [OPW-1:0]  op_q, op_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic            waiting, tmo, retire, use_op;
  assign waiting = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  // Watchdog fires on the TMO-th consecutive wait cycle; a same-cycle mem_ready wins.
  assign tmo = rst_n && waiting && !mem_ready && wait_q == WW'(TMO - 1);
  assign wait_d = (waiting && !mem_ready && !tmo) ? wait_q + 1'b1 : '0;
  assign op_d = state_q == S_DECODE ? op : op_q;
  assign retired_d = retired_q + CNTW'(retire);
  assign dec_ns = (op >= OPW'(1) && op <= OPW'(11)) ? S_EXEC :
                  (op == OP_LW || op == OP_SW)      ? S_MEMADR :
                  (op == OP_AI0 || op == OP_AI1)    ? S_ADDIEX :
                  op == OP_BEQ                      ? S_BRANCH :
                  op == OP_J                        ? S_JUMP :
                  op == OP_JAL                      ? S_JAL :
                  op == OP_JR                       ? S_JR : S_FETCH;
  assign illegal = state_q == S_DECODE && dec_ns == S_FETCH;
  assign mem_err = tmo;
  assign retired = retired_q;
  assign use_op = state_q inside {S_EXEC, S_ADDIEX, S_BRANCH};
  assign aluop = use_op ? op_q[OPW-1:OPW-2] : 2'b10;
  assign funct = use_op ? op_q[3:0] : 4'b0010;
  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    pcwrite_br = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    jalsrc     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = !tmo;
        alusrcb = tmo ? 2'b00 : 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        state_d = dec_ns;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = op_q == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = !tmo;
        memread = !tmo;
        state_d = mem_ready ? S_MEMWB : tmo ? S_FETCH : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = !tmo;
        memwrite = !tmo;
        retire   = mem_ready;
        state_d  = (mem_ready || tmo) ? S_FETCH : S_MEMWR;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        pcsrc      = 2'b01;
        pcwrite_br = zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        jalsrc   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: directed and randomized checks of mc_maindec against a per-instruction model.
module tb_mc_maindec;
  localparam int TMO = 4;
  localparam int CNTW = 4;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, zero = 1'b0;
  logic [5:0] op = '0;
  logic pcwrite, pcwrite_br, iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, jalsrc, illegal, mem_err;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] funct;
  logic [CNTW-1:0] retired;
  mc_maindec #(.OPW(6), .CNTW(CNTW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .zero(zero),
    .pcwrite(pcwrite), .pcwrite_br(pcwrite_br), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .jalsrc(jalsrc), .aluop(aluop), .funct(funct), .illegal(illegal),
    .mem_err(mem_err), .retired(retired)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic pcwrite, pcwrite_br, iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic jalsrc;
    logic [1:0] aluop;
    logic [3:0] funct;
    logic illegal, mem_err;
  } outs_t;
  typedef enum {C_ALU, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL} cls_t;
  outs_t hist[$];
  int checks = 0, failures = 0;
  logic [CNTW-1:0] exp_ret = '0;
  logic [5:0] legal[11] = '{6'h01, 6'h05, 6'h0B, 6'h20, 6'h21, 6'h22, 6'h2B, 6'h10, 6'h30, 6'h31, 6'h33};

  function automatic outs_t snap();
    return {pcwrite, pcwrite_br, iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
            alusrcb, pcsrc, jalsrc, aluop, funct, illegal, mem_err};
  endfunction

  function automatic cls_t classify(input logic [5:0] o);
    if (o >= 6'd1 && o <= 6'd11) return C_ALU;
    case (o)
      6'h20: return C_LW;
      6'h21: return C_SW;
      6'h22, 6'h2B: return C_ADDI;
      6'h10: return C_BEQ;
      6'h30: return C_J;
      6'h31: return C_JAL;
      6'h33: return C_JR;
      default: return C_ILL;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] o, input logic z);
    mem_ready = r;
    op = o;
    zero = z;
    #3;
    hist.push_back(snap());
    @(posedge clk);
    #1;
  endtask

  // Runs one whole instruction with nf fetch waits and nd data waits; zm: 0/1 fixed zero, 2 random.
  task automatic run_instr(input logic [5:0] o, input int nf, input int nd, input int zm);
    cls_t c = classify(o);
    bit mem = c inside {C_LW, C_SW};
    bit ctl = c inside {C_BEQ, C_J, C_JAL, C_JR};
    int len = nf + (c == C_ILL ? 2 : ctl ? 3 : c == C_LW ? nd + 5 : c == C_SW ? nd + 4 : 4);
    int ds = nf + 3;
    int n_ir = 0, n_mr = 0, n_mw = 0, n_io = 0, n_rw = 0, n_rd = 0, n_mt = 0, n_js = 0, n_pw = 0, n_br = 0, n_il = 0, n_me = 0;
    logic zb = 1'b0;
    hist.delete();
    for (int i = 0; i < len; i++) begin
      logic r, z;
      r = i <= nf ? (i == nf) : (mem && i >= ds) ? (i == ds + nd) : 1'($urandom);
      z = zm == 2 ? 1'($urandom) : 1'(zm);
      if (i == len - 1) zb = z;
      cyc(r, i == nf + 1 ? o : 6'($urandom), z);
    end
    foreach (hist[i]) begin
      n_ir += hist[i].irwrite; n_mr += hist[i].memread; n_mw += hist[i].memwrite; n_io += hist[i].iord;
      n_rw += hist[i].regwrite; n_rd += hist[i].regdst & hist[i].regwrite; n_mt += hist[i].memtoreg;
      n_js += hist[i].jalsrc; n_pw += hist[i].pcwrite; n_br += hist[i].pcwrite_br;
      n_il += hist[i].illegal; n_me += hist[i].mem_err;
    end
    chk("irwrite_at_fetch_end", hist[nf].irwrite, 1);
    chk("irwrite_count", n_ir, 1);
    chk("memread_count", n_mr, nf + 1 + (c == C_LW ? nd + 1 : 0));
    chk("memwrite_count", n_mw, c == C_SW ? nd + 1 : 0);
    chk("iord_count", n_io, mem ? nd + 1 : 0);
    chk("regwrite_count", n_rw, (c inside {C_ALU, C_ADDI, C_LW, C_JAL}) ? 1 : 0);
    chk("regdst_count", n_rd, c == C_ALU ? 1 : 0);
    chk("memtoreg_count", n_mt, c == C_LW ? 1 : 0);
    chk("jalsrc_count", n_js, c == C_JAL ? 1 : 0);
    chk("pcwrite_count", n_pw, 1 + ((c inside {C_J, C_JAL, C_JR}) ? 1 : 0));
    chk("pcwrite_br_count", n_br, (c == C_BEQ && zb) ? 1 : 0);
    chk("illegal_count", n_il, c == C_ILL ? 1 : 0);
    chk("mem_err_count", n_me, 0);
    chk("fetch_aluop_funct", {hist[0].aluop, hist[0].funct}, 6'b100010);
    chk("decode_alusrcb", {hist[nf + 1].alusrca, hist[nf + 1].alusrcb}, 3'b011);
    if (len > nf + 2)
      chk("exec_aluop_funct", {hist[nf + 2].aluop, hist[nf + 2].funct},
          (c inside {C_ALU, C_ADDI, C_BEQ}) ? o : 6'b100010);
    if (ctl)
      chk("ctl_pcsrc", hist[len - 1].pcsrc, c == C_BEQ ? 2'b01 : c == C_JR ? 2'b11 : 2'b10);
    if (c != C_ILL) exp_ret++;
    chk("retired", retired, exp_ret);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memread", memread, 1);
    chk("rst_enables", {irwrite, pcwrite, regwrite, memwrite, iord}, 0);
    chk("rst_traps", {illegal, mem_err}, 0);
    chk("rst_retired", retired, 0);
    rst_n = 1'b1;
    run_instr(6'h01, 0, 0, 2);
    chk("add_wb_regwrite_regdst", {hist[3].regwrite, hist[3].regdst}, 2'b11);
    chk("add_exec_alusrca", hist[2].alusrca, 1);
    run_instr(6'h20, 0, 3, 2);
    chk("lw_memrd_hold", {hist[5].memread, hist[5].iord}, 2'b11);
    chk("lw_memwb_memtoreg", hist[7].memtoreg, 1);
    run_instr(6'h10, 0, 0, 1);
    chk("beq_z1_pcwrite_br", hist[2].pcwrite_br, 1);
    chk("beq_aluop_funct", {hist[2].aluop, hist[2].funct}, 6'b010000);
    run_instr(6'h10, 0, 0, 0);
    chk("beq_z0_pcwrite_br", hist[2].pcwrite_br, 0);
    run_instr(6'h3F, 0, 0, 2);
    chk("ill_decode_pulse", {hist[1].illegal, hist[1].regwrite, hist[1].memwrite}, 3'b100);
    hist.delete();
    repeat (TMO) cyc(1'b0, 6'($urandom), 1'b0);
    chk("tmo_early_no_err", hist[TMO - 2].mem_err, 0);
    chk("tmo_err_pulse", {hist[TMO - 1].mem_err, hist[TMO - 1].memread, hist[TMO - 1].irwrite}, 3'b100);
    chk("tmo_retired", retired, exp_ret);
    run_instr(6'h30, TMO - 1, 0, 2);
    chk("retired_five", retired, 5);
    hist.delete();
    cyc(1'b1, 6'($urandom), 1'b0);
    cyc(1'b0, 6'h21, 1'b0);
    cyc(1'b0, 6'($urandom), 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("sw_memwrite_before_rst", memwrite, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_memwrite", {memwrite, iord, memread}, 3'b001);
    chk("async_rst_retired", retired, 0);
    exp_ret = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist.delete();
    cyc(1'b1, 6'($urandom), 1'b0);
    cyc(1'b0, 6'h20, 1'b0);
    cyc(1'b0, 6'($urandom), 1'b0);
    repeat (TMO) cyc(1'b0, 6'($urandom), 1'b0);
    chk("memrd_wait_memread", hist[5].memread, 1);
    chk("memrd_tmo", {hist[6].mem_err, hist[6].memread, hist[6].iord, hist[6].regwrite}, 4'b1000);
    chk("memrd_tmo_retired", retired, 0);
    for (int k = 0; k < 40; k++)
      run_instr($urandom_range(0, 1) ? legal[$urandom_range(0, 10)] : 6'($urandom),
                $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
